// File: rtl/dly_tap_sequencer_pkg.sv
// Shared definitions for the delay-tap calibration sequencer: widths, default
// tap count and the sequencer state encoding.
package dly_tap_sequencer_pkg;

  localparam int ADDR_W       = 5;
  localparam int TAP_W        = 6;
  localparam int NUM_TAPS_DEF = 20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_COMPARE = 3'd2,
    ST_ADJUST  = 3'd3,
    ST_WAIT    = 3'd4,
    ST_NEXT    = 3'd5,
    ST_FINISH  = 3'd6
  } state_t;

endpackage

// File: rtl/dly_target_table.sv
// Per-tap calibration target storage: one synchronous write port and one
// asynchronous read port; out-of-range writes are dropped.
module dly_target_table
  import dly_tap_sequencer_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [TAP_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [TAP_W-1:0]  o_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);

  logic [TAP_W-1:0] r_mem [NUM_TAPS];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr <= LAST_ADDR)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_raddr <= LAST_ADDR) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/dly_tap_sequencer.sv
// Walks every enabled delay tap, nudging it one step at a time until its
// readback matches the stored target or the per-tap step budget runs out.
module dly_tap_sequencer
  import dly_tap_sequencer_pkg::*;
#(
  parameter int NUM_TAPS      = NUM_TAPS_DEF,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_STEPS     = 63
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NUM_TAPS-1:0] i_tap_en,
  input  logic                i_target_we,
  input  logic [ADDR_W-1:0]   i_target_addr,
  input  logic [TAP_W-1:0]    i_target_val,
  input  logic [TAP_W-1:0]    i_dly_tap_value,
  output logic [ADDR_W-1:0]   o_dly_addr,
  output logic                o_dly_adj,
  output logic                o_dly_incdec,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [ADDR_W-1:0]   o_err_addr
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_TAPS - 1);
  localparam logic [3:0]        SETTLE_END = 4'(SETTLE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_first;
  logic [STEP_W-1:0]   r_steps;
  logic [3:0]          r_settle;
  logic                r_incdec;
  logic                r_error;
  logic [ADDR_W-1:0]   r_err_addr;

  logic [TAP_W-1:0]    w_target;
  logic                w_match;
  logic                w_settled;
  logic                w_exhausted;
  logic                w_at_last;
  logic [ADDR_W-1:0]   w_addr_inc;
  logic [ADDR_W-1:0]   w_cand_addr;
  logic                w_cand_en;
  logic                w_table_we;

  // Table writes are only honoured while no pass is using the targets.
  assign w_table_we = i_target_we && !o_busy;

  dly_target_table #(
    .NUM_TAPS (NUM_TAPS)
  ) u_table (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_table_we),
    .i_waddr (i_target_addr),
    .i_wdata (i_target_val),
    .i_raddr (r_addr),
    .o_rdata (w_target)
  );

  assign w_match     = (w_target == i_dly_tap_value);
  assign w_settled   = (r_settle == SETTLE_END);
  assign w_exhausted = (r_steps >= STEP_LIMIT);
  assign w_at_last   = (r_addr == LAST_ADDR);
  assign w_addr_inc  = r_addr + ADDR_W'(1);
  // The first NEXT cycle of a pass evaluates tap 0 itself rather than advancing.
  assign w_cand_addr = r_first ? r_addr : w_addr_inc;
  assign w_cand_en   = i_tap_en[w_cand_addr];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_state_next = ST_NEXT;
      ST_SELECT:  if (w_settled) w_state_next = ST_COMPARE;
      ST_COMPARE: begin
        if (w_match || w_exhausted) w_state_next = ST_NEXT;
        else                        w_state_next = ST_ADJUST;
      end
      ST_ADJUST:  w_state_next = ST_WAIT;
      ST_WAIT:    if (w_settled) w_state_next = ST_COMPARE;
      ST_NEXT: begin
        if (!r_first && w_at_last) w_state_next = ST_FINISH;
        else if (w_cand_en)        w_state_next = ST_SELECT;
        else                       w_state_next = ST_NEXT;
      end
      ST_FINISH:  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_dly_adj = (r_state == ST_ADJUST);
    o_busy    = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    o_done    = (r_state == ST_FINISH);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr     <= '0;
      r_first    <= 1'b0;
      r_steps    <= '0;
      r_settle   <= '0;
      r_incdec   <= 1'b0;
      r_error    <= 1'b0;
      r_err_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_error    <= 1'b0;
            r_err_addr <= '0;
            r_addr     <= '0;
            r_first    <= 1'b1;
          end
        end
        ST_SELECT: begin
          r_steps  <= '0;
          r_settle <= w_settled ? 4'd0 : r_settle + 4'd1;
        end
        ST_WAIT: begin
          r_settle <= w_settled ? 4'd0 : r_settle + 4'd1;
        end
        ST_COMPARE: begin
          if (!w_match && !w_exhausted) begin
            r_incdec <= (w_target > i_dly_tap_value);
          end
          if (!w_match && w_exhausted) begin
            r_error <= 1'b1;
            if (!r_error) r_err_addr <= r_addr;
          end
        end
        ST_ADJUST: begin
          r_steps <= r_steps + STEP_W'(1);
        end
        ST_NEXT: begin
          r_first <= 1'b0;
          if (r_first || !w_at_last) r_addr <= w_cand_addr;
        end
        default: ;
      endcase
    end
  end

  assign o_dly_addr   = r_addr;
  assign o_dly_incdec = r_incdec;
  assign o_error      = r_error;
  assign o_err_addr   = r_err_addr;

endmodule
